// File: rtl/softmax_row.sv
// Row-wise fixed-point softmax: per row max, base-2 exp approximation, sum, restoring divide.
// state     | meaning: IDLE wait start | MAX row max | EXP exp+sum | DIV_LOAD/ITER/WRITE divide one element
module softmax_row #(
  parameter int DATA_WIDTH = 32,
  parameter int SEQ_LEN    = 64,
  parameter int FRAC_BITS  = 14,
  parameter int LOG2E_Q    = 23637
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] i_scores_flat,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] o_probs_flat
);

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int PW = DATA_WIDTH + 33;
  localparam logic [IW-1:0]         LAST    = IW'(SEQ_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_W   = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [PW-1:0]  LOG2E_W = PW'(LOG2E_Q);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MAX       = 3'd1;
  localparam logic [2:0] S_EXP       = 3'd2;
  localparam logic [2:0] S_DIV_LOAD  = 3'd3;
  localparam logic [2:0] S_DIV_ITER  = 3'd4;
  localparam logic [2:0] S_DIV_WRITE = 3'd5;

  logic [2:0]                   r_state;
  logic [IW-1:0]                r_row;
  logic [IW-1:0]                r_col;
  logic [BW-1:0]                r_bit;
  logic signed [DATA_WIDTH-1:0] r_mx;
  logic [DATA_WIDTH-1:0]        r_sum;
  logic [DATA_WIDTH-1:0]        r_quo;
  logic [DATA_WIDTH-1:0]        r_rem;
  logic [DATA_WIDTH-1:0]        r_ebuf [SEQ_LEN];

  int                           w_elem;
  logic signed [DATA_WIDTH-1:0] w_s;
  logic signed [DATA_WIDTH:0]   w_x;
  logic signed [PW-1:0]         w_xe;
  logic signed [PW-1:0]         w_prod;
  logic signed [PW-1:0]         w_t;
  logic [PW-1:0]                w_u;
  logic [PW-1:0]                w_ui;
  logic [FRAC_BITS-1:0]         w_uf;
  logic [DATA_WIDTH-1:0]        w_mant;
  logic [DATA_WIDTH-1:0]        w_e;
  logic [DATA_WIDTH:0]          w_trial;
  logic [DATA_WIDTH:0]          w_diff;

  assign w_elem = int'(r_row) * SEQ_LEN + int'(r_col);
  assign w_s    = i_scores_flat[w_elem*DATA_WIDTH +: DATA_WIDTH];

  // x is one bit wider than a score so that max - min never wraps
  assign w_x    = {w_s[DATA_WIDTH-1], w_s} - {r_mx[DATA_WIDTH-1], r_mx};
  assign w_xe   = {{(PW-DATA_WIDTH-1){w_x[DATA_WIDTH]}}, w_x};
  assign w_prod = w_xe * LOG2E_W;
  assign w_t    = w_prod >>> FRAC_BITS;
  assign w_u    = -w_t;
  assign w_ui   = w_u >> FRAC_BITS;
  assign w_uf   = w_u[FRAC_BITS-1:0];
  assign w_mant = ONE_W - {{(DATA_WIDTH-FRAC_BITS+1){1'b0}}, w_uf[FRAC_BITS-1:1]};
  assign w_e    = (w_ui >= PW'(FRAC_BITS + 1)) ? '0 : (w_mant >> w_ui);

  assign w_trial = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_sum};

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_bit        <= '0;
      r_mx         <= '0;
      r_sum        <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      o_done       <= 1'b0;
      o_probs_flat <= '0;
      for (int k = 0; k < SEQ_LEN; k++) r_ebuf[k] <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_MAX;
            r_row   <= '0;
            r_col   <= '0;
            r_sum   <= '0;
          end
        end
        S_MAX: begin
          if (r_col == '0 || w_s > r_mx) r_mx <= w_s;
          if (r_col == LAST) begin
            r_col   <= '0;
            r_state <= S_EXP;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_EXP: begin
          r_ebuf[r_col] <= w_e;
          r_sum         <= r_sum + w_e;
          if (r_col == LAST) begin
            r_col   <= '0;
            r_state <= S_DIV_LOAD;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DIV_LOAD: begin
          r_quo   <= r_ebuf[r_col] << FRAC_BITS;
          r_rem   <= '0;
          r_bit   <= BW'(DATA_WIDTH - 1);
          r_state <= S_DIV_ITER;
        end
        S_DIV_ITER: begin
          // quotient bits shift in from the bottom as dividend bits leave the top
          if (!w_diff[DATA_WIDTH]) begin
            r_rem <= w_diff[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_trial[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
          end
          if (r_bit == '0) r_state <= S_DIV_WRITE;
          else             r_bit   <= r_bit - 1'b1;
        end
        S_DIV_WRITE: begin
          o_probs_flat[w_elem*DATA_WIDTH +: DATA_WIDTH] <= r_quo;
          if (r_col == LAST) begin
            r_col <= '0;
            r_sum <= '0;
            if (r_row == LAST) begin
              r_row   <= '0;
              r_state <= S_IDLE;
              o_done  <= 1'b1;
            end else begin
              r_row   <= r_row + 1'b1;
              r_state <= S_MAX;
            end
          end else begin
            r_col   <= r_col + 1'b1;
            r_state <= S_DIV_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row.sv
// Self-checking bench for softmax_row: directed rows, random rows, reset abort and start handshake.
module tb_softmax_row;
  localparam int DW   = 32;
  localparam int SL   = 4;
  localparam int FB   = 14;
  localparam int FLAT = DW * SL * SL;
  localparam int LAT  = SL * (2 * SL + SL * (DW + 2));

  logic            clk;
  logic            i_rst;
  logic            i_start;
  logic [FLAT-1:0] scores;
  logic            o_busy;
  logic            o_done;
  logic [FLAT-1:0] o_probs_flat;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_row #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .FRAC_BITS(FB), .LOG2E_Q(23637)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_scores_flat(scores),
    .o_busy(o_busy), .o_done(o_done), .o_probs_flat(o_probs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: softmax rules evaluated directly with 64-bit integer arithmetic.
  function automatic logic [FLAT-1:0] model(input logic [FLAT-1:0] s);
    logic [FLAT-1:0]    p;
    logic signed [DW-1:0] w;
    longint v [SL];
    longint e [SL];
    longint mx, x, t, u, ui, uf, sum;
    p = '0;
    for (int m = 0; m < SL; m++) begin
      for (int n = 0; n < SL; n++) begin
        w = s[(m*SL+n)*DW +: DW];
        v[n] = longint'(w);
      end
      mx = v[0];
      for (int n = 1; n < SL; n++) if (v[n] > mx) mx = v[n];
      sum = 0;
      for (int n = 0; n < SL; n++) begin
        x = v[n] - mx;
        t = (x * 23637) >>> FB;
        u = -t;
        ui = u >> FB;
        uf = u & ((64'd1 << FB) - 1);
        e[n] = (ui >= FB + 1) ? 0 : (((64'd1 << FB) - (uf >> 1)) >> ui);
        sum += e[n];
      end
      for (int n = 0; n < SL; n++) p[(m*SL+n)*DW +: DW] = DW'((e[n] << FB) / sum);
    end
    return p;
  endfunction

  task automatic set_row(input int m, input int a, input int b, input int c, input int d);
    scores[(m*SL+0)*DW +: DW] = a;
    scores[(m*SL+1)*DW +: DW] = b;
    scores[(m*SL+2)*DW +: DW] = c;
    scores[(m*SL+3)*DW +: DW] = d;
  endtask

  task automatic rand_row(input int m, input int r);
    for (int n = 0; n < SL; n++)
      scores[(m*SL+n)*DW +: DW] = (r == 0) ? $urandom : (int'($urandom_range(0, 2*r)) - r);
  endtask

  task automatic check_probs(input string tag, input logic [FLAT-1:0] e);
    for (int k = 0; k < SL*SL; k++)
      chk($sformatf("%s_p%0d", tag, k), longint'(o_probs_flat[k*DW +: DW]), longint'(e[k*DW +: DW]));
  endtask

  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == pulse_at) i_start = 1'b1;
      else if (n == pulse_at + 1) i_start = 1'b0;
      if (o_done) break;
    end
    if (!o_done) chk("timeout", 0, 1);
  endtask

  task automatic run_check(input string tag, input int pulse_at);
    int n;
    logic [FLAT-1:0] e;
    e = model(scores);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    chk({tag, "_busy_on"}, longint'(o_busy), 1);
    wait_done(pulse_at, n);
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_off"}, longint'(o_busy), 0);
    check_probs(tag, e);
    @(posedge clk);
    #1 chk({tag, "_done_pulse"}, longint'(o_done), 0);
  endtask

  initial begin
    int n;
    logic [FLAT-1:0] e;
    i_rst = 1'b1;
    i_start = 1'b0;
    scores = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_done", longint'(o_done), 0);
    chk("rst_probs", longint'(|o_probs_flat), 0);
    i_rst = 1'b0;

    // all zero scores: uniform 4096
    run_check("zeros", -5);
    chk("zeros_lit", longint'(o_probs_flat[5*DW +: DW]), 4096);

    set_row(0, 16384, 0, 0, 0);
    set_row(1, 0, 0, 0, 0);
    set_row(2, 32*16384, 0, 0, 0);
    set_row(3, -5*16384, -5*16384, -5*16384, -5*16384);
    run_check("directed", -5);
    chk("lit_7557", longint'(o_probs_flat[0*DW +: DW]), 7557);
    chk("lit_2942", longint'(o_probs_flat[1*DW +: DW]), 2942);
    chk("lit_sat1", longint'(o_probs_flat[8*DW +: DW]), 16384);
    chk("lit_sat0", longint'(o_probs_flat[9*DW +: DW]), 0);
    chk("lit_neg", longint'(o_probs_flat[14*DW +: DW]), 4096);

    set_row(0, 32'h7FFFFFFF, 32'h80000000, 0, 0);
    rand_row(1, 16384); rand_row(2, 4*16384); rand_row(3, 0);
    run_check("extreme", -5);
    chk("ext_p0", longint'(o_probs_flat[0*DW +: DW]), 16384);
    chk("ext_p1", longint'(o_probs_flat[1*DW +: DW]), 0);

    for (int r = 0; r < 3; r++) begin
      for (int m = 0; m < SL; m++) rand_row(m, 3 * 16384);
      run_check($sformatf("rand%0d", r), -5);
    end

    // reset lands in row 2 DIV_ITER
    for (int m = 0; m < SL; m++) rand_row(m, 2 * 16384);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (300) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", longint'(o_busy), 0);
    chk("abort_done", longint'(o_done), 0);
    chk("abort_probs", longint'(|o_probs_flat), 0);
    i_rst = 1'b0;
    run_check("after_rst", -5);

    for (int m = 0; m < SL; m++) rand_row(m, 16384);
    run_check("ign_start", 100);

    // start held through done restarts immediately
    for (int m = 0; m < SL; m++) rand_row(m, 3 * 16384);
    e = model(scores);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(-5, n);
    chk("held_lat1", n, LAT);
    check_probs("held1", e);
    for (int m = 0; m < SL; m++) rand_row(m, 16384);
    e = model(scores);
    @(posedge clk);
    #1;
    chk("held_restart", longint'(o_busy), 1);
    i_start = 1'b0;
    wait_done(-5, n);
    chk("held_lat2", n, LAT);
    check_probs("held2", e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
